// File: rtl/execute_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module execute_muldiv #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned DW = 2 * XLEN;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_q, neg_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Accept-time operand conditioning
    logic              sgn_a, sgn_b, a_neg, b_neg, is_div;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, a_sext;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special;

    // One iteration of the datapath and the final result it yields
    logic [XLEN:0]     sum, r65, diff;
    logic              ge;
    logic [DW-1:0]     acc_n, prod, prod_s;
    logic [XLEN-1:0]   mres, dv, dres, raw, fin;

    always_comb begin
        is_div = op[2];
        sgn_a  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sgn_b  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_sext = {{(XLEN-32){a[31]}}, a[31:0]};
        a_ext  = word ? (sgn_a ? a_sext : {{(XLEN-32){1'b0}}, a[31:0]}) : a;
        b_ext  = word ? (sgn_b ? {{(XLEN-32){b[31]}}, b[31:0]} : {{(XLEN-32){1'b0}}, b[31:0]})
                      : b;
        a_neg  = sgn_a && a_ext[XLEN-1];
        b_neg  = sgn_b && b_ext[XLEN-1];
        a_mag  = a_neg ? -a_ext : a_ext;
        b_mag  = b_neg ? -b_ext : b_ext;

        div_zero = is_div && (b_ext == '0);
        // Most-negative / -1 at the operating width; a_ext is already sign-extended for W
        div_ovf  = is_div && sgn_a && (&b_ext) &&
                   (a_ext == (word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
        if (div_zero) begin
            special = op[1] ? (word ? a_sext : a) : '1;
        end else begin
            special = op[1] ? '0 : a_ext;
        end

        sum  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        r65  = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
        diff = r65 - {1'b0, mcand_q};
        ge   = ~diff[XLEN];
        if (op_q[2]) begin
            acc_n = {(ge ? diff[XLEN-1:0] : r65[XLEN-1:0]), acc_q[XLEN-2:0], ge};
        end else begin
            acc_n = {sum, acc_q[XLEN-1:1]};
        end

        // After 32 multiply steps the product sits 32 bits above bit 0
        prod   = word_q ? {32'b0, acc_n[DW-1:32]} : acc_n;
        prod_s = neg_q ? -prod : prod;
        mres   = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[DW-1:XLEN];
        dv     = op_q[1] ? acc_n[DW-1:XLEN] : acc_n[XLEN-1:0];
        dres   = neg_q ? -dv : dv;
        raw    = op_q[2] ? dres : mres;
        fin    = word_q ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        result_d = result_q;

        case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    op_d   = op;
                    word_d = word;
                    cnt_d  = word ? 7'd32 : 7'd64;
                    if (is_div) begin
                        neg_d   = op[1] ? a_neg : (a_neg ^ b_neg);
                        acc_d   = {{XLEN{1'b0}}, (word ? {a_mag[31:0], 32'b0} : a_mag)};
                        mcand_d = b_mag;
                    end else begin
                        neg_d   = a_neg ^ b_neg;
                        acc_d   = {{XLEN{1'b0}}, b_mag};
                        mcand_d = a_mag;
                    end
                    if (div_zero || div_ovf) begin
                        result_d = special;
                        state_d  = StDone;
                    end else begin
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = acc_n;
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) begin
                    result_d = fin;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed-vector bench for execute_muldiv: results, latency, hold, flush and reset.
module tb_execute_muldiv;
    localparam logic [2:0] OpMul = 3'd0, OpMulh = 3'd1, OpMulhsu = 3'd2, OpMulhu = 3'd3;
    localparam logic [2:0] OpDiv = 3'd4, OpDivu = 3'd5, OpRem = 3'd6, OpRemu = 3'd7;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    execute_muldiv #(.XLEN(64)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .word     (word),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, measure latency (accept edge counts as 1),
    // optionally hold out_ready low for some cycles, then consume.
    task automatic do_op(input string tag, input logic [2:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y,
                         input logic [63:0] exp, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op = o; word = w; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = 3'($urandom); word = ~w;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq({tag, " hold result"}, result, exp);
            check_eq({tag, " hold busy"}, 64'(busy), 64'd1);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        check_eq({tag, " idle after consume"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        int seen;
        #12;
        check_eq("reset result", result, 64'd0);
        check_eq("reset flags", {60'd0, in_ready, busy, out_valid, 1'b0}, 64'b1000);
        @(negedge clk); resetn = 1'b1;

        do_op("MUL 7*-3", OpMul, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
              64'hFFFF_FFFF_FFFF_FFEB, 65, 5);
        do_op("MULHU -1*-1", OpMulhu, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
        do_op("MULH -1*-1", OpMulh, 1'b0, '1, '1, 64'd0, 65, 0);
        do_op("MULHSU -1*2", OpMulhsu, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        do_op("DIV -7/2", OpDiv, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        do_op("REM -7%2", OpRem, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65, 0);
        do_op("DIVU 7/0", OpDivu, 1'b0, 64'd7, 64'd0, '1, 1, 0);
        do_op("REMU 7%0", OpRemu, 1'b0, 64'd7, 64'd0, 64'd7, 1, 0);
        do_op("DIV ovf", OpDiv, 1'b0, 64'h8000_0000_0000_0000, '1,
              64'h8000_0000_0000_0000, 1, 0);
        do_op("REM ovf", OpRem, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
        do_op("DIVW ovf", OpDiv, 1'b1, 64'h0000_0001_8000_0000, '1,
              64'hFFFF_FFFF_8000_0000, 1, 0);
        do_op("MULW", OpMul, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
        do_op("DIVW -7/2", OpDiv, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
              64'hFFFF_FFFF_FFFF_FFFD, 33, 0);
        do_op("REMUW x/0", OpRemu, 1'b1, 64'h0000_0001_8000_0007, 64'd0,
              64'hFFFF_FFFF_8000_0007, 1, 0);

        // Flush at CALC cycle 10
        @(negedge clk);
        in_valid = 1'b1; op = OpDivu; word = 1'b0; a = 64'd100; b = 64'd7;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check_eq("flush idle", {62'd0, in_ready, busy}, 64'b10);
        check_eq("flush out_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("flush no output", 64'(seen), 64'd0);
        do_op("DIVU 100/7", OpDivu, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);

        // Flush coinciding with a request in IDLE
        @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = OpDivu; b = 64'd0;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        check_eq("flush blocks accept", {62'd0, busy, in_ready}, 64'b01);

        // Asynchronous reset mid-op
        @(negedge clk);
        in_valid = 1'b1; op = OpMul; word = 1'b0; a = 64'd3; b = 64'd5;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3; resetn = 1'b0;
        #1;
        check_eq("async reset flags", {61'd0, in_ready, busy, out_valid}, 64'b100);
        check_eq("async reset result", result, 64'd0);
        @(negedge clk); resetn = 1'b1;
        seen = 0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("no partial output", 64'(seen), 64'd0);

        // Back-to-back with out_ready tied high: accept, consume, accept, ...
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; op = OpDivu; word = 1'b1; a = 64'd9; b = 64'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("b2b busy %0d", i), 64'(busy), (i % 2 == 0) ? 64'd1 : 64'd0);
            if (i % 2 == 0) check_eq($sformatf("b2b result %0d", i), result, '1);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
